reg_dump_unit: RTL and testbench
================================

REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

Interface
REQ-001 Parameter: NUM_REGS, 32, number of register-file entries dumped after the PC (range 1..32).
REQ-002 Parameter: DATA_W, 32, width of the PC and register words.
REQ-003 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: start  input  1  request a dump; sampled only in IDLE.
REQ-006 Port: pc_in  input  DATA_W  live CPU program counter.
REQ-007 Port: rf_raddr  output  5  register-file read address.
REQ-008 Port: rf_rdata  input  DATA_W  register-file read data; combinational from rf_raddr in the same cycle.
REQ-009 Port: dump_valid  output  1  dump_data and dump_index are valid.
REQ-010 Port: dump_ready  input  1  sink accepts the current beat.
REQ-011 Port: dump_data  output  DATA_W  dumped word.
REQ-012 Port: dump_index  output  6  beat number: 0 = PC, k = register k-1.
REQ-013 Port: busy  output  1  a dump is in progress.
REQ-014 Port: halt_cpu  output  1  freeze request to the CPU (PC and register-file writes).
REQ-015 Port: done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-016 States SHALL be IDLE, SEND and DONE.
REQ-017 IDLE with start=1 SHALL set dump_data<=pc_in, dump_index<=0, rf_raddr<=0, dump_valid<=1, busy<=1, halt_cpu<=1, and go to SEND; dump_valid is therefore high 1 cycle after start.
REQ-018 A handshake SHALL be dump_valid=1 and dump_ready=1 on the same rising edge.
REQ-019 SEND with a handshake and dump_index=k<NUM_REGS SHALL set dump_data<=rf_rdata, dump_index<=k+1, rf_raddr<=k+1 (5-bit truncated), and stay in SEND.
REQ-020 SEND with a handshake and dump_index=NUM_REGS SHALL set dump_valid<=0, done<=1, and go to DONE.
REQ-021 SEND without a handshake SHALL hold dump_data, dump_index, rf_raddr and dump_valid unchanged.
REQ-022 With dump_ready held high, beats SHALL issue on consecutive cycles: NUM_REGS+1 beats in NUM_REGS+1 cycles.
REQ-023 DONE SHALL last exactly one cycle, then clear done, busy and halt_cpu and go to IDLE.
REQ-024 start SHALL be ignored in SEND and DONE; start in the first IDLE cycle after DONE SHALL be accepted.
REQ-025 halt_cpu SHALL equal busy: high from the cycle after start through the DONE cycle, low otherwise.
REQ-026 dump_valid SHALL be low in IDLE and DONE.
REQ-027 dump_ready SHALL be ignored when dump_valid=0.
REQ-028 The PC word SHALL be the value of pc_in in the cycle start was accepted.

Reset
REQ-029 rst_n=0 SHALL immediately, asynchronously and regardless of state, force state=IDLE and set dump_valid, dump_data, dump_index, rf_raddr, busy, halt_cpu and done to 0.
REQ-030 A dump interrupted by reset SHALL NOT resume; the next accepted start SHALL begin again at dump_index=0.

Verification
REQ-031 Basic: pc_in=0x00000040, reg[i]=0x100+i, dump_ready=1, start pulse at cycle 0 -> beats on cycles 1..33 with (index,data) = (0,0x40), (1,0x100) ... (32,0x11F); done=1 on cycle 34 only; busy and halt_cpu high on cycles 1..34.
REQ-032 Backpressure: same setup, dump_ready=0 on cycles 1..3 and alternating thereafter -> beat 0 (index 0, data 0x40) held unchanged through cycles 1..3; no beat skipped or duplicated; all 33 beats delivered in order.
REQ-033 Start while busy: start re-pulsed at cycles 5 and 34 -> no restart, dump_index sequence unaffected; start at cycle 35 -> new beat 0 at cycle 36.
REQ-034 Reset mid-dump: rst_n low for 2 cycles after beat 10 is accepted -> all outputs 0 during reset; after a new start, dump_index restarts at 0 with the current pc_in.
REQ-035 NUM_REGS=4: start with reg[0..3]=0xA,0xB,0xC,0xD and dump_ready=1 -> 5 beats with indices 0..4 and data PC,0xA,0xB,0xC,0xD; done on cycle 6.
REQ-036 PC snapshot: pc_in changes on the cycle after start -> beat 0 carries the value from the start cycle.

Source files
------------

// File: rtl/reg_dump_if.sv
// Dump stream: one beat per handshake, carrying a word and its beat number.
interface reg_dump_if #(
  parameter int DATA_W = 32
);
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [5:0]        dump_index;

  modport master (output dump_valid, dump_data, dump_index, input dump_ready);
  modport slave  (input dump_valid, dump_data, dump_index, output dump_ready);
endinterface

// File: rtl/reg_dump_unit.sv
// Register dump unit: freezes the CPU, streams the PC then NUM_REGS
// register-file words over a valid/ready channel, pulses done at the end.
module reg_dump_unit #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] pc_in,
  output logic [4:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  reg_dump_if.master        dump,
  output logic              busy,
  output logic              halt_cpu,
  output logic              done
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_t;

  localparam logic [5:0] LAST_IDX = 6'(NUM_REGS);

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [5:0]        idx_q,   idx_d;
  logic [4:0]        raddr_q, raddr_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              hs;

  // Beat accepted this edge; ready is meaningless while valid is low.
  assign hs = valid_q & dump.dump_ready;

  // Next-state and next-output logic. rf_raddr always points at the
  // register that feeds the *next* beat, so rf_rdata is ready at handshake.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    raddr_d = raddr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEND;
          valid_d = 1'b1;
          data_d  = pc_in;
          idx_d   = 6'd0;
          raddr_d = 5'd0;
          busy_d  = 1'b1;
        end
      end
      ST_SEND: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            data_d  = rf_rdata;
            idx_d   = idx_q + 6'd1;
            raddr_d = idx_q[4:0] + 5'd1;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any dump in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      raddr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      raddr_q <= raddr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dump.dump_valid = valid_q;
  assign dump.dump_data  = data_q;
  assign dump.dump_index = idx_q;
  assign rf_raddr        = raddr_q;
  assign busy            = busy_q;
  assign halt_cpu        = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Scoreboard bench for reg_dump_unit: stimulus pushes the expected beat list
// when a start is accepted; a negedge monitor pops and compares on handshakes.
module tb_reg_dump_unit;
  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] pc_in;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        busy, halt_cpu, done;
  logic [31:0] rf [32];

  // small instance
  logic        start4;
  logic [31:0] pc4;
  logic [4:0]  rf_raddr4;
  logic [31:0] rf_rdata4;
  logic        busy4, halt4, done4;
  logic [31:0] rf4 [32];

  reg_dump_if #(.DATA_W(32)) dif ();
  reg_dump_if #(.DATA_W(32)) dif4 ();

  always #5 clk = ~clk;

  assign rf_rdata  = rf[rf_raddr];
  assign rf_rdata4 = rf4[rf_raddr4];

  reg_dump_unit #(.NUM_REGS(NR), .DATA_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc_in(pc_in),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dump(dif),
    .busy(busy), .halt_cpu(halt_cpu), .done(done));

  reg_dump_unit #(.NUM_REGS(4), .DATA_W(32)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .pc_in(pc4),
    .rf_raddr(rf_raddr4), .rf_rdata(rf_rdata4), .dump(dif4),
    .busy(busy4), .halt_cpu(halt4), .done(done4));

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] data;
  } beat_t;

  beat_t sb[$];
  bit    in_done = 1'b0;
  int    n_pass  = 0;
  int    n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: busy/halt follow "dump outstanding", valid follows "queue non-empty".
  always @(negedge clk) begin
    beat_t b;
    bit    exp_busy;
    if (rst_n) begin
      exp_busy = (sb.size() != 0) || in_done;
      chk("busy", busy, exp_busy);
      chk("halt_cpu", halt_cpu, exp_busy);
      chk("done", done, in_done);
      chk("dump_valid", dif.dump_valid, sb.size() != 0);
      in_done = 1'b0;
      if (dif.dump_valid && sb.size() != 0) begin
        b = sb[0];
        chk("dump_index", dif.dump_index, b.idx);
        chk("dump_data", dif.dump_data, b.data);
        if (b.idx < NR) chk("rf_raddr", rf_raddr, b.idx[4:0]);
        if (dif.dump_ready) begin
          void'(sb.pop_front());
          if (b.idx == NR) in_done = 1'b1;
        end
      end
    end
  end

  // mode 0: ready always high; 1: low for 3 cycles then alternating; 2: random.
  task automatic do_dump(input int mode, input logic [31:0] pc, input bit spurious);
    int cyc;
    bit seen;
    @(posedge clk); #1;
    pc_in = pc;
    start = 1'b1;
    dif.dump_ready = (mode == 0);
    @(posedge clk);
    sb.push_back('{idx: 6'd0, data: pc});
    for (int k = 1; k <= NR; k++) sb.push_back('{idx: 6'(k), data: rf[k-1]});
    #1;
    start = 1'b0;
    pc_in = $urandom;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 400) begin
      case (mode)
        0:       dif.dump_ready = 1'b1;
        1:       dif.dump_ready = (cyc > 3) && (cyc % 2 == 0);
        default: dif.dump_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (mode == 0) start = spurious && (cyc == 5 || cyc == NR + 2);
      else           start = spurious && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    if (!seen) begin
      $display("FAIL done_timeout: got no done expected done within 400 cycles");
      $fatal(1, "dump did not finish");
    end
    if (mode == 0) chk("done_cycle", cyc, NR + 2);
  endtask

  initial begin
    logic [31:0] exp4 [5];
    rst_n = 1'b0;
    start = 1'b0;
    start4 = 1'b0;
    pc_in = 32'h0;
    pc4 = 32'h0;
    dif.dump_ready = 1'b0;
    dif4.dump_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rf[i]  = 32'h100 + i;
      rf4[i] = 32'hdead0000 + i;
    end
    rf4[0] = 32'hA; rf4[1] = 32'hB; rf4[2] = 32'hC; rf4[3] = 32'hD;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", dif.dump_valid, 0);
    chk("rst_data", dif.dump_data, 0);
    chk("rst_index", dif.dump_index, 0);
    chk("rst_raddr", rf_raddr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halt", halt_cpu, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // NUM_REGS=4 instance, directed: PC snapshot then A..D, done on cycle 6
    @(posedge clk); #1;
    start4 = 1'b1; pc4 = 32'h1234_5678; dif4.dump_ready = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; pc4 = 32'hFFFF_0000;
    exp4[0] = 32'h1234_5678; exp4[1] = 32'hA; exp4[2] = 32'hB; exp4[3] = 32'hC; exp4[4] = 32'hD;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c <= 5) begin
        chk("n4_valid", dif4.dump_valid, 1);
        chk("n4_index", dif4.dump_index, c - 1);
        chk("n4_data", dif4.dump_data, exp4[c-1]);
      end else chk("n4_valid", dif4.dump_valid, 0);
      chk("n4_done", done4, c == 6);
      chk("n4_busy", busy4, c <= 6);
      chk("n4_halt", halt4, c <= 6);
    end

    // basic, ready always high, spurious starts at cycles 5 and 34
    do_dump(0, 32'h40, 1'b1);
    // start accepted in the first idle cycle after DONE, with backpressure
    do_dump(1, 32'h40, 1'b0);

    // randomized dumps
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      do_dump(2, $urandom, 1'b1);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        dif.dump_ready = $urandom_range(0, 1);
      end
    end

    // reset after beat 10 is accepted
    @(posedge clk); #1;
    pc_in = 32'hCAFE_0001;
    start = 1'b1;
    dif.dump_ready = 1'b1;
    @(posedge clk);
    sb.push_back('{idx: 6'd0, data: 32'hCAFE_0001});
    for (int k = 1; k <= NR; k++) sb.push_back('{idx: 6'(k), data: rf[k-1]});
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    in_done = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("mid_rst_valid", dif.dump_valid, 0);
      chk("mid_rst_data", dif.dump_data, 0);
      chk("mid_rst_index", dif.dump_index, 0);
      chk("mid_rst_raddr", rf_raddr, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_halt", halt_cpu, 0);
      chk("mid_rst_done", done, 0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    do_dump(0, 32'h0BAD_F00D, 1'b0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
